// File: rtl/debug_trace_pkg.sv
`timescale 1ns/1ps
// Shared types and defaults for the debug trace capture controller.
// With DEBUG_TRACE_TIMESTAMP_EN defined the log record carries a timestamp field.
package debug_trace_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    POST  = 2'd2,
    DONE  = 2'd3
  } trace_state_e;

  localparam int DEF_W     = 5;
  localparam int DEF_NSRC  = 4;
  localparam int DEF_SRC_W = $clog2(DEF_NSRC);
  localparam int DEF_CNT_W = 8;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  localparam int DEF_TS_W  = 16;
`endif

  // Log record layout for the default configuration, MSB first.
  typedef struct packed {
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    logic [DEF_TS_W-1:0]  ts;
`endif
    logic [DEF_SRC_W-1:0] src_tag;
    logic [DEF_W-1:0]     payload;
  } log_rec_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/debug_rr_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter: picks the first valid at or after the pointer, wrapping.
// The pointer advances past the winner; all other valids are reported as ungranted.
module debug_rr_arbiter #(
  parameter int NSRC  = 4,
  parameter int SRC_W = $clog2(NSRC)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NSRC-1:0]  valid,
  output logic [NSRC-1:0]  grant,
  output logic [SRC_W-1:0] grant_idx,
  output logic             grant_vld,
  output logic [NSRC-1:0]  ungranted
);

  logic [SRC_W-1:0] ptr_q;
  logic [SRC_W-1:0] idx;
  int               sum;

  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    grant     = '0;
    idx       = '0;
    sum       = 0;
    for (int k = 0; k < NSRC; k++) begin
      sum = int'(ptr_q) + k;
      if (sum >= NSRC) begin
        sum = sum - NSRC;
      end
      idx = SRC_W'(sum);
      if (!grant_vld && valid[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
    if (grant_vld) begin
      grant[grant_idx] = 1'b1;
    end
    ungranted = valid & ~grant;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (grant_vld) begin
      if (grant_idx == SRC_W'(NSRC - 1)) begin
        ptr_q <= '0;
      end else begin
        ptr_q <= grant_idx + 1'b1;
      end
    end
  end

endmodule

// File: rtl/debug_trace_ctrl.sv
`timescale 1ns/1ps
// Capture controller in front of the debug log FIFO: arbitrates event sources,
// waits for a trigger, logs post-trigger samples, then freezes. Option: DEBUG_TRACE_TIMESTAMP_EN.
module debug_trace_ctrl
  import debug_trace_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int NSRC  = DEF_NSRC,
  parameter int SRC_W = $clog2(NSRC),
  parameter int CNT_W = DEF_CNT_W,
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  parameter int TS_W  = DEF_TS_W,
  localparam int LOG_W = TS_W + SRC_W + W
`else
  localparam int LOG_W = SRC_W + W
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              arm,
  input  logic              disarm,
  input  logic [NSRC-1:0]   src_valid,
  input  logic [NSRC*W-1:0] src_data,
  input  logic [SRC_W-1:0]  trig_src,
  input  logic [W-1:0]      trig_mask,
  input  logic [W-1:0]      trig_value,
  input  logic [CNT_W-1:0]  post_count,
  output logic              log_en,
  output logic [LOG_W-1:0]  log_data,
  output logic              log_clr,
  output logic [1:0]        state,
  output logic              triggered,
  output logic [CNT_W-1:0]  sample_cnt,
  output logic [CNT_W-1:0]  drop_cnt
);

  // Sources are fire-and-forget strobes with no ready; log_en is a one-cycle
  // write strobe with log_data valid in the same cycle, and the FIFO never stalls us.

  trace_state_e     state_q;
  logic [CNT_W-1:0] remain;

  logic [NSRC-1:0]  grant;
  logic [SRC_W-1:0] grant_idx;
  logic             grant_vld;
  logic [NSRC-1:0]  ungranted;

  logic [W-1:0]     gdata;
  logic             hit;
  logic             capturing;
  logic [3:0]       drops;
  logic [CNT_W:0]   drop_sum;
  logic [CNT_W-1:0] drop_next;
  logic [CNT_W-1:0] sample_next;
  logic [LOG_W-1:0] rec;

  debug_rr_arbiter #(
    .NSRC  (NSRC),
    .SRC_W (SRC_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .valid     (src_valid),
    .grant     (grant),
    .grant_idx (grant_idx),
    .grant_vld (grant_vld),
    .ungranted (ungranted)
  );

`ifdef DEBUG_TRACE_TIMESTAMP_EN
  logic [TS_W-1:0] ts_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_q + 1'b1;
    end
  end

  assign rec = {ts_q, grant_idx, gdata};
`else
  assign rec = {grant_idx, gdata};
`endif

  always_comb begin
    gdata = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (grant[i]) begin
        gdata = src_data[W*i +: W];
      end
    end
  end

  assign hit = grant_vld && (grant_idx == trig_src) &&
               ((gdata & trig_mask) == (trig_value & trig_mask));

  assign capturing = (state_q == ARMED) || (state_q == POST);

  // Both counters saturate at all-ones rather than wrapping.
  assign drops       = popcount8(8'(ungranted));
  assign drop_sum    = {1'b0, drop_cnt} + (CNT_W + 1)'(drops);
  assign drop_next   = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
  assign sample_next = (sample_cnt == '1) ? sample_cnt : sample_cnt + 1'b1;

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      remain     <= '0;
      log_en     <= 1'b0;
      log_data   <= '0;
      log_clr    <= 1'b0;
      triggered  <= 1'b0;
      sample_cnt <= '0;
      drop_cnt   <= '0;
    end else begin
      log_en  <= 1'b0;
      log_clr <= 1'b0;
      if (disarm) begin
        state_q <= IDLE;
      end else if (arm) begin
        // Restart from any state; nothing granted this cycle is logged.
        state_q    <= ARMED;
        remain     <= post_count;
        log_clr    <= 1'b1;
        triggered  <= 1'b0;
        sample_cnt <= '0;
        drop_cnt   <= '0;
      end else if (capturing && grant_vld) begin
        log_en     <= 1'b1;
        log_data   <= rec;
        sample_cnt <= sample_next;
        drop_cnt   <= drop_next;
        if (state_q == ARMED) begin
          if (hit) begin
            triggered <= 1'b1;
            state_q   <= (remain == '0) ? DONE : POST;
          end
        end else begin
          remain <= remain - 1'b1;
          if (remain == CNT_W'(1)) begin
            state_q <= DONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_debug_trace_ctrl.sv
`timescale 1ns/1ps
// Directed bench for debug_trace_ctrl: expected log records go into a queue,
// a negedge monitor pops and compares whenever log_en is seen.
module tb_debug_trace_ctrl;
  import debug_trace_pkg::*;

  localparam int W     = 5;
  localparam int NSRC  = 4;
  localparam int SRC_W = 2;
  localparam int CNT_W = 8;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
  localparam int TS_W  = 16;
  localparam int LOG_W = TS_W + SRC_W + W;
`else
  localparam int LOG_W = SRC_W + W;
`endif

  logic              clk;
  logic              rst;
  logic              arm;
  logic              disarm;
  logic [NSRC-1:0]   src_valid;
  logic [NSRC*W-1:0] src_data;
  logic [SRC_W-1:0]  trig_src;
  logic [W-1:0]      trig_mask;
  logic [W-1:0]      trig_value;
  logic [CNT_W-1:0]  post_count;
  logic              log_en;
  logic [LOG_W-1:0]  log_data;
  logic              log_clr;
  logic [1:0]        state;
  logic              triggered;
  logic [CNT_W-1:0]  sample_cnt;
  logic [CNT_W-1:0]  drop_cnt;

  logic [LOG_W-1:0]  exp_q[$];
  logic [LOG_W-1:0]  exp_rec;
  int                checks;
  int                failures;
  int                clr_seen;
  int                clr0;
  logic [15:0]       ts_model;

  debug_trace_ctrl #(
    .W     (W),
    .NSRC  (NSRC),
    .CNT_W (CNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .arm        (arm),
    .disarm     (disarm),
    .src_valid  (src_valid),
    .src_data   (src_data),
    .trig_src   (trig_src),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .post_count (post_count),
    .log_en     (log_en),
    .log_data   (log_data),
    .log_clr    (log_clr),
    .state      (state),
    .triggered  (triggered),
    .sample_cnt (sample_cnt),
    .drop_cnt   (drop_cnt)
  );

  // Clock and reset-tracking cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst) ts_model <= '0;
    else     ts_model <= ts_model + 16'd1;
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    if (log_clr) clr_seen++;
    if (log_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL log_unexpected act=%0h exp=none", log_data);
      end else begin
        exp_rec = exp_q.pop_front();
        if (log_data !== exp_rec) begin
          failures++;
          $display("FAIL log_data act=%0h exp=%0h", log_data, exp_rec);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [NSRC-1:0] v, input logic [NSRC*W-1:0] d);
    src_valid = v;
    src_data  = d;
    @(negedge clk);
    src_valid = '0;
  endtask

  task automatic push(input logic [SRC_W-1:0] tag, input logic [W-1:0] pl);
    log_rec_t r;
`ifdef DEBUG_TRACE_TIMESTAMP_EN
    r.ts = ts_model;
`endif
    r.src_tag = tag;
    r.payload = pl;
    exp_q.push_back(r);
  endtask

  task automatic do_arm(input logic [CNT_W-1:0] pc);
    post_count = pc;
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  function automatic logic [NSRC*W-1:0] pack4(input logic [W-1:0] d0, input logic [W-1:0] d1,
                                              input logic [W-1:0] d2, input logic [W-1:0] d3);
    return {d3, d2, d1, d0};
  endfunction

  initial begin
    #5000000;
    failures++;
    $display("FAIL timeout act=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    logic [W-1:0]      pl[4];
    logic [NSRC*W-1:0] d_all;
    int                guard;
    checks = 0; failures = 0; clr_seen = 0;
    arm = 0; disarm = 0; src_valid = '0; src_data = '0;
    trig_src = '0; trig_mask = '0; trig_value = '0; post_count = '0;
    pl[0] = 5'h11; pl[1] = 5'h12; pl[2] = 5'h03; pl[3] = 5'h14;
    d_all = pack4(pl[0], pl[1], pl[2], pl[3]);

    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_state", 32'(state), 0);
    chk("rst_log_en", 32'(log_en), 0);
    chk("rst_log_data", 32'(log_data), 0);
    chk("rst_log_clr", 32'(log_clr), 0);
    chk("rst_triggered", 32'(triggered), 0);
    chk("rst_sample_cnt", 32'(sample_cnt), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);
    rst = 1'b0;
    trig_src = 2'd2; trig_mask = 5'h1F; trig_value = 5'h0A;

    // Events while IDLE are neither logged nor counted.
    repeat (4) step(4'b1111, d_all);
    chk("idle_drop", 32'(drop_cnt), 0);
    chk("idle_state", 32'(state), 0);
    chk("idle_sample", 32'(sample_cnt), 0);

    // Arm, then all four sources every cycle.
    clr0 = clr_seen;
    do_arm(8'd5);
    chk("arm_log_clr", 32'(log_clr), 1);
    chk("arm_state", 32'(state), 1);
    for (int k = 0; k < 4; k++) begin
      push(SRC_W'(k), pl[k]);
      step(4'b1111, d_all);
    end
    chk("rr_sample", 32'(sample_cnt), 4);
    chk("rr_drop", 32'(drop_cnt), 12);
    chk("rr_state", 32'(state), 1);
    chk("rr_clr_pulses", 32'(clr_seen - clr0), 1);

    // Trigger on src2 == 0x0A with three post samples.
    do_arm(8'd3);
    push(2'd2, 5'h0A); step(4'b0100, pack4(5'h00, 5'h00, 5'h0A, 5'h00));
    chk("trig_state", 32'(state), 2);
    chk("trig_flag", 32'(triggered), 1);
    push(2'd0, 5'h01); step(4'b0001, pack4(5'h01, 5'h00, 5'h00, 5'h00));
    push(2'd1, 5'h02); step(4'b0010, pack4(5'h00, 5'h02, 5'h00, 5'h00));
    push(2'd3, 5'h04); step(4'b1000, pack4(5'h00, 5'h00, 5'h00, 5'h04));
    chk("post_done", 32'(state), 3);
    chk("post_sample", 32'(sample_cnt), 4);
    step(4'b1111, pack4(5'h01, 5'h02, 5'h0A, 5'h04));
    chk("done_state", 32'(state), 3);
    chk("done_sample", 32'(sample_cnt), 4);
    chk("done_drop", 32'(drop_cnt), 0);

    // Masked trigger with post_count = 0.
    trig_mask = 5'h18;
    do_arm(8'd0);
    chk("rearm_log_clr", 32'(log_clr), 1);
    chk("rearm_sample", 32'(sample_cnt), 0);
    chk("rearm_trig", 32'(triggered), 0);
    push(2'd2, 5'h12); step(4'b0100, pack4(5'h00, 5'h00, 5'h12, 5'h00));
    chk("mask_miss_state", 32'(state), 1);
    push(2'd2, 5'h0F); step(4'b0100, pack4(5'h00, 5'h00, 5'h0F, 5'h00));
    chk("pc0_state", 32'(state), 3);
    chk("pc0_sample", 32'(sample_cnt), 2);
    chk("pc0_trig", 32'(triggered), 1);
    step(4'b0100, pack4(5'h00, 5'h00, 5'h0F, 5'h00));
    chk("pc0_hold", 32'(sample_cnt), 2);

    // Saturation of both counters, then arm+disarm together.
    do_arm(8'd10);
    for (int k = 0; k < 260; k++) begin
      push(SRC_W'((3 + k) % 4), pl[(3 + k) % 4]);
      step(4'b1111, d_all);
    end
    chk("sat_drop", 32'(drop_cnt), 255);
    chk("sat_sample", 32'(sample_cnt), 255);
    chk("sat_state", 32'(state), 1);
    clr0 = clr_seen;
    arm = 1'b1; disarm = 1'b1;
    @(negedge clk);
    arm = 1'b0; disarm = 1'b0;
    chk("armdis_state", 32'(state), 0);
    chk("armdis_log_clr", 32'(log_clr), 0);
    step('0, d_all);
    chk("armdis_clr_pulses", 32'(clr_seen - clr0), 0);
    chk("armdis_sample_hold", 32'(sample_cnt), 255);
    chk("armdis_drop_hold", 32'(drop_cnt), 255);

    // Reset mid-capture squashes the pending sample and the rr pointer.
    do_arm(8'd5);
    push(2'd0, 5'h11); step(4'b0001, d_all);
    chk("pre_rst_sample", 32'(sample_cnt), 1);
    rst = 1'b1;
    step(4'b0001, d_all);
    chk("midrst_log_en", 32'(log_en), 0);
    chk("midrst_state", 32'(state), 0);
    chk("midrst_sample", 32'(sample_cnt), 0);
    chk("midrst_log_data", 32'(log_data), 0);
    rst = 1'b0;
    do_arm(8'd5);
    push(2'd0, 5'h11); step(4'b1111, d_all);
    chk("postrst_sample", 32'(sample_cnt), 1);
    chk("postrst_drop", 32'(drop_cnt), 3);

`ifdef DEBUG_TRACE_TIMESTAMP_EN
    // Timestamp wrap and spacing.
    guard = 0;
    while (ts_model != 16'hFFFF && guard < 70000) begin
      @(negedge clk);
      guard++;
    end
    chk("ts_wait_bound", 32'(guard < 70000), 1);
    exp_q.push_back({16'hFFFF, 2'd1, 5'h12}); step(4'b0010, d_all);
    exp_q.push_back({16'h0000, 2'd2, 5'h03}); step(4'b0100, d_all);
    exp_q.push_back({16'h0001, 2'd3, 5'h14}); step(4'b1000, d_all);
    repeat (9) step('0, d_all);
    exp_q.push_back({16'h000B, 2'd0, 5'h11}); step(4'b0001, d_all);
`else
    guard = 0;
`endif

    repeat (3) step('0, d_all);
    chk("queue_drained", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
